// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// UartTx : byte-wide, valid/ready fed UART transmitter (8 data bits, LSB
// first, 1 stop bit).  Every frame bit is held for WAIT_COUNT clock cycles,
// where WAIT_COUNT = (CLK_FREQ_MHZ*1e6)/BAUD_RATE and must be at least 2.
//
// Optional feature (compile-time macro UART_TX_PARITY_EN):
//    when defined, an even-parity bit is inserted between the last data bit
//    and the stop bit (8E1, 11-bit frame).  Without it the frame is 8N1.
//
// Ports:
//    clk_i     in   1  system clock, all state changes on the rising edge
//    rst_i     in   1  asynchronous active-high reset
//    wvalid_i  in   1  a byte is offered for transmission
//    wready_o  out  1  block accepts a byte this cycle (registered)
//    wdata_i   in   8  byte to send, LSB first
//    txd_o     out  1  serial line, idle high (registered, glitch-free)
//    busy_o    out  1  high while any frame bit is on the line
// ---------------------------------------------------------------------------
module uart_tx #(
   parameter int CLK_FREQ_MHZ = 100,
   parameter int BAUD_RATE    = 921600
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       wvalid_i,
   output logic       wready_o,
   input  logic [7:0] wdata_i,
   output logic       txd_o,
   output logic       busy_o
);

   localparam int WAIT_COUNT = (CLK_FREQ_MHZ * 1000000) / BAUD_RATE;
   localparam int CNT_W      = $clog2(WAIT_COUNT);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_COUNT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd4,
`endif
      STOP   = 3'd3
   } state_t;

   state_t           r_state;
   state_t           w_stateNext;
   logic [CNT_W-1:0] r_baudCnt;
   logic [CNT_W-1:0] w_baudCntNext;
   logic [3:0]       r_bitCnt;
   logic [3:0]       w_bitCntNext;
   logic [7:0]       r_shift;
   logic [7:0]       w_shiftNext;
   logic             r_txd;
   logic             w_txdNext;
   logic             r_wready;
   logic             w_wreadyNext;
   logic             r_busy;
   logic             w_busyNext;
   logic             w_bitDone;
`ifdef UART_TX_PARITY_EN
   logic             r_parity;
   logic             w_parityNext;
`endif

   // The last cycle of the current frame bit; every state that drives a
   // bit leaves (or advances) on this cycle.
   assign w_bitDone = (r_baudCnt == CNT_LAST);

   // State register plus all registered outputs.  Reset is asynchronous so
   // the line returns to idle immediately and any aborted frame is dropped.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_baudCnt <= '0;
         r_bitCnt  <= '0;
         r_shift   <= '0;
         r_txd     <= 1'b1;
         r_wready  <= 1'b1;
         r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         r_state   <= w_stateNext;
         r_baudCnt <= w_baudCntNext;
         r_bitCnt  <= w_bitCntNext;
         r_shift   <= w_shiftNext;
         r_txd     <= w_txdNext;
         r_wready  <= w_wreadyNext;
         r_busy    <= w_busyNext;
`ifdef UART_TX_PARITY_EN
         r_parity  <= w_parityNext;
`endif
      end
   end

   // Next-state logic.  Outputs are computed one cycle ahead here and then
   // registered, so txd_o changes exactly on the edge where a bit starts.
   // The shift register is pre-shifted: when a bit begins, r_shift[0] is
   // loaded onto the line and the register moves right for the next one.
   always_comb begin
      w_stateNext   = r_state;
      w_baudCntNext = r_baudCnt;
      w_bitCntNext  = r_bitCnt;
      w_shiftNext   = r_shift;
      w_txdNext     = r_txd;
      w_wreadyNext  = r_wready;
      w_busyNext    = r_busy;
`ifdef UART_TX_PARITY_EN
      w_parityNext  = r_parity;
`endif

      case (r_state)
         IDLE: begin
            w_txdNext    = 1'b1;
            w_wreadyNext = 1'b1;
            w_busyNext   = 1'b0;
            if (wvalid_i && r_wready) begin
               w_stateNext   = START;
               w_shiftNext   = wdata_i;
               w_baudCntNext = '0;
               w_bitCntNext  = '0;
               w_txdNext     = 1'b0;
               w_wreadyNext  = 1'b0;
               w_busyNext    = 1'b1;
`ifdef UART_TX_PARITY_EN
               w_parityNext  = ^wdata_i;
`endif
            end
         end

         START: begin
            if (w_bitDone) begin
               w_stateNext   = DATA;
               w_baudCntNext = '0;
               w_bitCntNext  = '0;
               w_txdNext     = r_shift[0];
               w_shiftNext   = {1'b0, r_shift[7:1]};
            end else begin
               w_baudCntNext = r_baudCnt + CNT_ONE;
            end
         end

         DATA: begin
            if (w_bitDone) begin
               w_baudCntNext = '0;
               if (r_bitCnt == 4'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_stateNext = PARITY;
                  w_txdNext   = r_parity;
`else
                  w_stateNext = STOP;
                  w_txdNext   = 1'b1;
`endif
               end else begin
                  w_bitCntNext = r_bitCnt + 4'd1;
                  w_txdNext    = r_shift[0];
                  w_shiftNext  = {1'b0, r_shift[7:1]};
               end
            end else begin
               w_baudCntNext = r_baudCnt + CNT_ONE;
            end
         end

`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (w_bitDone) begin
               w_stateNext   = STOP;
               w_baudCntNext = '0;
               w_txdNext     = 1'b1;
            end else begin
               w_baudCntNext = r_baudCnt + CNT_ONE;
            end
         end
`endif

         STOP: begin
            w_txdNext = 1'b1;
            if (w_bitDone) begin
               w_stateNext   = IDLE;
               w_baudCntNext = '0;
               w_bitCntNext  = '0;
               w_wreadyNext  = 1'b1;
               w_busyNext    = 1'b0;
            end else begin
               w_baudCntNext = r_baudCnt + CNT_ONE;
            end
         end

         // Unused encodings fall back to a clean idle line.
         default: begin
            w_stateNext   = IDLE;
            w_baudCntNext = '0;
            w_bitCntNext  = '0;
            w_txdNext     = 1'b1;
            w_wreadyNext  = 1'b1;
            w_busyNext    = 1'b0;
         end
      endcase
   end

   assign txd_o    = r_txd;
   assign wready_o = r_wready;
   assign busy_o   = r_busy;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ_MHZ, default 100, system clock frequency in MHz.
REQ-002 SHALL have parameter BAUD_RATE, default 921600, serial bit rate in bit/s.
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wvalid_i  input  1  byte offered for transmission.
REQ-006 SHALL have port wready_o  output  1  block can accept a byte this cycle.
REQ-007 SHALL have port wdata_i  input  8  byte to send, LSB transmitted first.
REQ-008 SHALL have port txd_o  output  1  serial line, idle high.
REQ-009 SHALL have port busy_o  output  1  high while any frame bit is being driven.

Function
REQ-010 SHALL define WAIT_COUNT = (CLK_FREQ_MHZ*1000000)/BAUD_RATE, integer division; every frame bit held exactly WAIT_COUNT cycles; WAIT_COUNT >= 2 required.
REQ-011 SHALL size the baud counter to $clog2(WAIT_COUNT) bits; the bit counter to 4 bits.
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP (PARITY added per REQ-024).
REQ-013 SHALL transfer a byte when wvalid_i && wready_o at a rising edge; wdata_i latched into a shift register at that edge.
REQ-014 SHALL drive wready_o registered: high only in IDLE, low from the cycle after a transfer until STOP completes.
REQ-015 SHALL move IDLE->START on transfer; txd_o goes 0 on the very next cycle (latency 1 cycle, txd_o registered, glitch-free).
REQ-016 SHALL move START->DATA after WAIT_COUNT cycles; DATA emits bits 0..7 LSB first, shifting once per WAIT_COUNT cycles.
REQ-017 SHALL move DATA->STOP after the 8th bit; STOP drives txd_o=1 for WAIT_COUNT cycles, then ->IDLE with wready_o=1.
REQ-018 SHALL give minimum spacing between consecutive start-bit falling edges of 10*WAIT_COUNT+1 cycles (one IDLE cycle) under continuous wvalid_i.
REQ-019 SHALL ignore wvalid_i and wdata_i while wready_o=0; changes to wdata_i after transfer do not affect the frame in progress.
REQ-020 SHALL assert busy_o in START/DATA/STOP(/PARITY), deassert in IDLE.
REQ-021 SHALL recover any unreachable state encoding to IDLE with txd_o=1 on the next cycle.

Reset
REQ-022 SHALL, while rst_i=1 (asynchronously, independent of clk_i), force state=IDLE, txd_o=1, wready_o=1, busy_o=0, counters=0; an aborted frame is not resumed.
REQ-023 SHALL accept a transfer at the first rising edge after rst_i deasserts.

Configuration
REQ-024 SHALL, with macro UART_TX_PARITY_EN defined, insert state PARITY between DATA and STOP driving even parity (XOR of 8 data bits) for WAIT_COUNT cycles; frame = 11 bits, spacing 11*WAIT_COUNT+1.
REQ-025 SHALL, without UART_TX_PARITY_EN, contain no parity logic; frame = 10 bits (8N1).

Verification (CLK_FREQ_MHZ=1, BAUD_RATE=250000 -> WAIT_COUNT=4)
REQ-026 SHALL verify single byte: send 0x55 -> txd_o samples per 4 cycles = 0,1,0,1,0,1,0,1,0,1; wready_o low for 40 cycles, high again after.
REQ-027 SHALL verify back-to-back: wvalid_i held high with 0xA3 then 0x0F -> both frames correct (0,1,1,0,0,0,1,0,1,1 / 0,1,1,1,1,0,0,0,0,1), start edges 41 cycles apart.
REQ-028 SHALL verify stall: wvalid_i asserted with 0xFF, wdata_i changed to 0x00 mid-frame -> frame still 0,1×8,1; no second transfer until wready_o=1.
REQ-029 SHALL verify reset mid-frame: assert rst_i during DATA bit 3 of 0x00 -> txd_o=1 and wready_o=1 immediately, no clock edge needed; next byte 0x81 sent cleanly.
REQ-030 SHALL verify parity (UART_TX_PARITY_EN): send 0x07 -> parity bit 1, frame 11 bits, 44 cycles; 0x03 -> parity bit 0.
REQ-031 SHALL verify idle: no wvalid_i for 1000 cycles after reset -> txd_o constant 1, busy_o constant 0.
